// File: rtl/count_step_pkg.sv
// Shared types and constants for the count_step decoder slice.
package count_step_pkg;

    // Lock-tracking state machine states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOST  = 2'd2
    } state_e;

    // Classification of one counter transition.
    typedef enum logic [1:0] {
        CLS_STEP    = 2'd0,
        CLS_RESET   = 2'd1,
        CLS_ILLEGAL = 2'd2
    } step_cls_e;

    // Step magnitudes the counter can produce; the modular deltas for a
    // given WIDTH are built from these (up = +n, down = 2^WIDTH - n).
    localparam int unsigned STEP_SMALL = 32'd1;
    localparam int unsigned STEP_LARGE = 32'd2;

    // Larger of two integers, used for sizing the shared run counter.
    function automatic int unsigned max_int(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/count_step_classify.sv
// Combinational classifier: maps one (q_prev -> q) transition to a step
// class plus the decoded direction and step size.
module count_step_classify
    import count_step_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_q_prev,
    output step_cls_e        o_cls,
    output logic             o_updown,
    output logic             o_inc
);

    localparam logic [WIDTH-1:0] L_DELTA_UP1 = WIDTH'(STEP_SMALL);
    localparam logic [WIDTH-1:0] L_DELTA_UP2 = WIDTH'(STEP_LARGE);
    localparam logic [WIDTH-1:0] L_DELTA_DN1 = WIDTH'(0) - WIDTH'(STEP_SMALL);
    localparam logic [WIDTH-1:0] L_DELTA_DN2 = WIDTH'(0) - WIDTH'(STEP_LARGE);

    logic [WIDTH-1:0] w_delta;

    assign w_delta = i_q - i_q_prev;

    // Legal deltas always win; a non-legal delta landing on zero is a counter reset.
    always_comb begin
        o_cls    = CLS_ILLEGAL;
        o_updown = 1'b0;
        o_inc    = 1'b0;
        case (w_delta)
            L_DELTA_UP1: begin
                o_cls    = CLS_STEP;
                o_updown = 1'b0;
                o_inc    = 1'b0;
            end
            L_DELTA_UP2: begin
                o_cls    = CLS_STEP;
                o_updown = 1'b0;
                o_inc    = 1'b1;
            end
            L_DELTA_DN1: begin
                o_cls    = CLS_STEP;
                o_updown = 1'b1;
                o_inc    = 1'b0;
            end
            L_DELTA_DN2: begin
                o_cls    = CLS_STEP;
                o_updown = 1'b1;
                o_inc    = 1'b1;
            end
            default: begin
                if (i_q == WIDTH'(0)) begin
                    o_cls = CLS_RESET;
                end else begin
                    o_cls = CLS_ILLEGAL;
                end
            end
        endcase
    end

endmodule

// File: rtl/count_step_decoder.sv
// Receive-side decoder for the up/down step counter: recovers the command
// behind each sampled transition, detects counter resets, flags illegal
// transitions and tracks lock (IDLE/TRACK/LOST).
module count_step_decoder
    import count_step_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 2,
    parameter int LOCK_LEN  = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             q_valid,
    input  logic [WIDTH-1:0] q,
    output logic             step_valid,
    output logic             updown,
    output logic             inc,
    output logic             reset_seen,
    output logic             step_err,
    output logic             synced,
    output logic [CNT_W-1:0] err_count
);

    // One run counter serves both the error run (TRACK) and the good run
    // (LOST); it clears on every state change so sharing is safe.
    localparam int RUN_MAX = max_int(ERR_LIMIT, LOCK_LEN);
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_q_prev;
    logic [RUN_W-1:0] r_run;
    logic [CNT_W-1:0] r_err_count;
    logic             r_updown;
    logic             r_inc;
    logic             r_step_valid;
    logic             r_reset_seen;
    logic             r_step_err;
    logic             r_synced;

    state_e           w_state_nxt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [RUN_W-1:0] w_run_inc;
    logic [CNT_W-1:0] w_err_count_nxt;
    logic             w_updown_nxt;
    logic             w_inc_nxt;
    logic             w_step_valid_nxt;
    logic             w_reset_seen_nxt;
    logic             w_step_err_nxt;
    step_cls_e        w_cls;
    logic             w_cls_updown;
    logic             w_cls_inc;

    count_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .i_q      (q),
        .i_q_prev (r_q_prev),
        .o_cls    (w_cls),
        .o_updown (w_cls_updown),
        .o_inc    (w_cls_inc)
    );

    assign w_run_inc = r_run + RUN_W'(1);

    // Decode pulses, held outputs, error counter and lock state machine.
    always_comb begin
        w_state_nxt      = r_state;
        w_run_nxt        = r_run;
        w_err_count_nxt  = r_err_count;
        w_updown_nxt     = r_updown;
        w_inc_nxt        = r_inc;
        w_step_valid_nxt = 1'b0;
        w_reset_seen_nxt = 1'b0;
        w_step_err_nxt   = 1'b0;
        if (q_valid) begin
            if (r_state == ST_IDLE) begin
                // First sample only seeds q_prev.
                w_state_nxt = ST_TRACK;
                w_run_nxt   = RUN_W'(0);
            end else begin
                case (w_cls)
                    CLS_STEP: begin
                        w_step_valid_nxt = 1'b1;
                        w_updown_nxt     = w_cls_updown;
                        w_inc_nxt        = w_cls_inc;
                    end
                    CLS_RESET: begin
                        w_reset_seen_nxt = 1'b1;
                    end
                    CLS_ILLEGAL: begin
                        w_step_err_nxt = 1'b1;
                        if (r_err_count != {CNT_W{1'b1}}) begin
                            w_err_count_nxt = r_err_count + CNT_W'(1);
                        end else begin
                            w_err_count_nxt = r_err_count;
                        end
                    end
                    default: begin
                        w_step_err_nxt = 1'b0;
                    end
                endcase

                case (r_state)
                    ST_TRACK: begin
                        if (w_cls == CLS_ILLEGAL) begin
                            if (w_run_inc >= RUN_W'(ERR_LIMIT)) begin
                                w_state_nxt = ST_LOST;
                                w_run_nxt   = RUN_W'(0);
                            end else begin
                                w_run_nxt = w_run_inc;
                            end
                        end else begin
                            w_run_nxt = RUN_W'(0);
                        end
                    end
                    ST_LOST: begin
                        if (w_cls == CLS_ILLEGAL) begin
                            w_run_nxt = RUN_W'(0);
                        end else if (w_run_inc >= RUN_W'(LOCK_LEN)) begin
                            w_state_nxt = ST_TRACK;
                            w_run_nxt   = RUN_W'(0);
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_run_nxt   = RUN_W'(0);
                    end
                endcase
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, history and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_q_prev     <= WIDTH'(0);
            r_run        <= RUN_W'(0);
            r_err_count  <= CNT_W'(0);
            r_updown     <= 1'b0;
            r_inc        <= 1'b0;
            r_step_valid <= 1'b0;
            r_reset_seen <= 1'b0;
            r_step_err   <= 1'b0;
            r_synced     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_run        <= w_run_nxt;
            r_err_count  <= w_err_count_nxt;
            r_updown     <= w_updown_nxt;
            r_inc        <= w_inc_nxt;
            r_step_valid <= w_step_valid_nxt;
            r_reset_seen <= w_reset_seen_nxt;
            r_step_err   <= w_step_err_nxt;
            // Rises one cycle after TRACK is entered, falls together with LOST.
            r_synced     <= (r_state == ST_TRACK) && (w_state_nxt == ST_TRACK);
            if (q_valid) begin
                r_q_prev <= q;
            end else begin
                r_q_prev <= r_q_prev;
            end
        end
    end

    assign step_valid = r_step_valid;
    assign updown     = r_updown;
    assign inc        = r_inc;
    assign reset_seen = r_reset_seen;
    assign step_err   = r_step_err;
    assign synced     = r_synced;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_count_step_decoder.sv
// Directed self-checking bench for count_step_decoder.
// Observed vector order: {step_valid, updown, inc, reset_seen, step_err, synced}.
module tb_count_step_decoder;

    logic       clk;
    logic       reset_n;
    logic       q_valid;
    logic [3:0] q;
    logic       step_valid;
    logic       updown;
    logic       inc;
    logic       reset_seen;
    logic       step_err;
    logic       synced;
    logic [7:0] err_count;

    int tests_run;
    int tests_failed;

    count_step_decoder #(
        .WIDTH     (4),
        .ERR_LIMIT (2),
        .LOCK_LEN  (2),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .q_valid    (q_valid),
        .q          (q),
        .step_valid (step_valid),
        .updown     (updown),
        .inc        (inc),
        .reset_seen (reset_seen),
        .step_err   (step_err),
        .synced     (synced),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {step_valid, updown, inc, reset_seen, step_err, synced};
    endfunction

    // Present one sample for exactly one rising edge; outputs are then sampled 1ns later.
    task automatic send(input logic [3:0] v);
        @(negedge clk);
        q_valid = 1'b1;
        q       = v;
        @(posedge clk);
        #1;
        q_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        q_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        q_valid = 1'b0;
        q       = 4'd0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({obs(), err_count} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_state got %b/%0d want 000000/0", obs(), err_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic_steps();
        logic [3:0] seq [5];
        logic [5:0] exp [5];
        seq = '{4'd3, 4'd4, 4'd6, 4'd5, 4'd3};
        exp = '{6'b000000, 6'b100001, 6'b101001, 6'b110001, 6'b111001};
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            tests_run++;
            if (obs() !== exp[i]) begin
                tests_failed++;
                $display("FAIL basic_step[%0d] got %b want %b", i, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] seq [3];
        logic [5:0] exp [3];
        apply_reset();
        seq = '{4'd14, 4'd0, 4'd15};
        exp = '{6'b000000, 6'b101001, 6'b110001};
        for (int i = 0; i < 3; i++) begin
            send(seq[i]);
            tests_run++;
            if (obs() !== exp[i]) begin
                tests_failed++;
                $display("FAIL wrap[%0d] got %b want %b", i, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_errors_and_lock();
        logic [3:0] seq [5];
        logic [5:0] exp [5];
        logic [7:0] ecnt [5];
        apply_reset();
        seq  = '{4'd5, 4'd9, 4'd12, 4'd13, 4'd14};
        exp  = '{6'b000000, 6'b000011, 6'b000010, 6'b100000, 6'b100000};
        ecnt = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd2};
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            tests_run++;
            if ({obs(), err_count} !== {exp[i], ecnt[i]}) begin
                tests_failed++;
                $display("FAIL err_lock[%0d] got %b/%0d want %b/%0d",
                         i, obs(), err_count, exp[i], ecnt[i]);
            end
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (obs() !== 6'b000001) begin
            tests_failed++;
            $display("FAIL relock_synced got %b want 000001", obs());
        end
    endtask

    task automatic test_reset_detect();
        logic [3:0] seq [3];
        logic [5:0] exp [3];
        apply_reset();
        seq = '{4'd7, 4'd0, 4'd0};
        exp = '{6'b000000, 6'b000101, 6'b000101};
        for (int i = 0; i < 3; i++) begin
            send(seq[i]);
            tests_run++;
            if ({obs(), err_count} !== {exp[i], 8'd0}) begin
                tests_failed++;
                $display("FAIL reset_detect[%0d] got %b/%0d want %b/0", i, obs(), err_count, exp[i]);
            end
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        send(4'd1);
        send(4'd2);
        tests_run++;
        if (obs() !== 6'b100001) begin
            tests_failed++;
            $display("FAIL gap_first got %b want 100001", obs());
        end
        // Junk on q while q_valid is low must be ignored.
        q = 4'd9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (obs() !== 6'b000001) begin
                tests_failed++;
                $display("FAIL gap_idle[%0d] got %b want 000001", i, obs());
            end
        end
        send(4'd3);
        tests_run++;
        if ({obs(), err_count} !== {6'b100001, 8'd0}) begin
            tests_failed++;
            $display("FAIL gap_after got %b/%0d want 100001/0", obs(), err_count);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        send(4'd0);
        send(4'd5);
        send(4'd10);
        send(4'd15);
        send(4'd4);
        tests_run++;
        if ({obs(), err_count} !== {6'b000010, 8'd4}) begin
            tests_failed++;
            $display("FAIL pre_reset got %b/%0d want 000010/4", obs(), err_count);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({obs(), err_count} !== 14'd0) begin
            tests_failed++;
            $display("FAIL async_reset got %b/%0d want 000000/0", obs(), err_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        send(4'd9);
        tests_run++;
        if (obs() !== 6'b000000) begin
            tests_failed++;
            $display("FAIL post_reset_first got %b want 000000", obs());
        end
        send(4'd10);
        tests_run++;
        if (obs() !== 6'b100001) begin
            tests_failed++;
            $display("FAIL post_reset_step got %b want 100001", obs());
        end
    endtask

    task automatic test_back_to_back_saturate();
        apply_reset();
        send(4'd5);
        for (int k = 1; k <= 300; k++) begin
            send((k % 2 == 1) ? 4'd9 : 4'd5);
            if (k == 254 || k == 255 || k == 300) begin
                tests_run++;
                if ({step_err, err_count} !== {1'b1, (k >= 255) ? 8'd255 : 8'd254}) begin
                    tests_failed++;
                    $display("FAIL saturate[%0d] got err=%b cnt=%0d want err=1 cnt=%0d",
                             k, step_err, err_count, (k >= 255) ? 255 : 254);
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_steps();
        test_wrap();
        test_errors_and_lock();
        test_reset_detect();
        test_gaps();
        test_async_reset();
        test_back_to_back_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
